program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction-memory interface that the CPU's fetch stage reads.
- Receives a little-endian byte stream from a UART receiver and assembles 32-bit instruction words.
- Writes each word into instruction ROM, then releases the CPU from reset.
- Sits between the UART receiver and the ROM write port; it also drives the CPU's reset_n.

Parameters:
- ROM_ADDRESS_BITWIDTH, 16: byte-address width of ROM. Capacity is MAX_WORDS = 2^(ROM_ADDRESS_BITWIDTH-2).
- TIMEOUT_CYCLES, 1000000: max idle cycles between bytes inside a frame. 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- rx_data  input  8  received byte, valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per byte. Back-to-back strobes (every cycle) are legal.
- rom_wren  output  1  ROM write strobe, one cycle per word.
- rom_address  output  ROM_ADDRESS_BITWIDTH  byte address of the word = word_index*4. Bits [1:0] are always 0.
- rom_write_data  output  32  assembled instruction word.
- cpu_reset_n  output  1  active-low CPU reset. Held 0 until the load completes.
- done  output  1  load completed successfully (sticky).
- error  output  1  load aborted (sticky).

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, reset_n).
  - While reset_n=0, all outputs = 0, state=S_LEN, and all counters and shift registers are cleared.
  - Reset asserted mid-load aborts the load. The next frame must start again from its length field.
- Frame format: 4-byte word count N, LSB first, then N words of 4 bytes each, LSB first.
- Byte assembly: each accepted byte is shifted into bits [31:24] while the existing contents shift right by 8.
  - A 2-bit byte counter tracks position and wraps 3->0 on the 4th byte.
- S_LEN (collecting the count): on the 4th byte, latch N.
  - N=0 -> S_DONE.
  - N>MAX_WORDS -> S_ERROR.
  - Otherwise -> S_DATA with word_index=0.
- S_DATA: when the 4th byte of a word has rx_valid at cycle t, the following hold at cycle t+1 for exactly one cycle:
  - rom_wren=1.
  - rom_address = word_index*4.
  - rom_write_data = the assembled word.
  - word_index then increments.
  - After the write of word N-1, state -> S_DONE. cpu_reset_n=1 and done=1 take effect from cycle t+2.
- rom_address and rom_write_data hold their last values when rom_wren=0.
- S_DONE: cpu_reset_n=1, done=1, rx_valid ignored. Only reset_n leaves this state.
- S_ERROR: cpu_reset_n=0, error=1, rom_wren=0, rx_valid ignored. Only reset_n leaves this state.
- Timeout:
  - The idle counter clears on every rx_valid.
  - It is armed only in S_DATA, or in S_LEN after at least 1 byte has been received.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no byte, -> S_ERROR.
  - Any write already issued is retained; a partial word is discarded.
- Simultaneous rx_valid and timeout expiry on the same cycle: the byte wins and the counter clears.
- Word count arithmetic: the word_index width is ROM_ADDRESS_BITWIDTH-1, so comparison with N=MAX_WORDS does not wrap. The last address is (MAX_WORDS-1)*4.
- rom_wren is never asserted outside S_DATA. done and error are never both 1.

Test Plan:
- Bytes 02 00 00 00 13 00 00 00 93 00 10 00, back-to-back -> rom_wren pulses:
  - addr 0x0000, data 0x00000013.
  - addr 0x0004, data 0x00100093.
  - Then cpu_reset_n=1 and done=1 two cycles after the last byte. Exactly 2 write pulses.
- Bytes 00 00 00 00 -> no rom_wren; done=1 and cpu_reset_n=1 one cycle after the 4th byte.
- With ROM_ADDRESS_BITWIDTH=4 (MAX_WORDS=4), count bytes 05 00 00 00 -> error=1, cpu_reset_n=0, no rom_wren. Extra bytes remain ignored.
- With TIMEOUT_CYCLES=10, send 01 00 00 00 AA BB, then idle 10 cycles -> error=1, no rom_wren. A subsequent byte is ignored.
- Bytes sent with 3-cycle gaps, N=1, word DEADBEEF sent as EF BE AD DE -> single write, addr 0, data 0xDEADBEEF, done=1.
- Assert reset_n=0 after 6 bytes of the 2-word frame, release, then resend the full frame -> outputs cleared asynchronously; the reload writes addr 0 and addr 4 correctly.

Source files
------------

// File: rtl/program_loader.sv
// Writer side of the instruction-memory interface: assembles a little-endian byte
// stream into 32-bit words, writes them to ROM, then releases the CPU from reset.
module program_loader #(
    parameter int ROM_ADDRESS_BITWIDTH = 16,
    parameter int TIMEOUT_CYCLES       = 1000000
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            done,
    output logic                            error
);
    localparam int          IW            = ROM_ADDRESS_BITWIDTH - 1;
    localparam logic [32:0] MAX_WORDS     = 33'd1 << (ROM_ADDRESS_BITWIDTH - 2);
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
    localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_LEN   = 2'd0,
        S_DATA  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t                          state_q, state_d;
    logic [31:0]                     shift_q, shift_d;
    logic [1:0]                      byte_cnt_q, byte_cnt_d;
    logic [IW-1:0]                   n_q, n_d;
    logic [IW-1:0]                   word_idx_q, word_idx_d;
    logic [31:0]                     idle_q, idle_d;
    logic                            rom_wren_q, rom_wren_d;
    logic [ROM_ADDRESS_BITWIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [31:0]                     rom_data_q, rom_data_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;
    logic                            cpu_rst_n_q, cpu_rst_n_d;

    logic [31:0] shift_next_s;
    logic        words_left_s;
    logic        accept_s;
    logic        armed_s;
    logic        timeout_s;
    logic        last_byte_s;

    assign shift_next_s = {rx_data, shift_q[31:8]};
    // index equals N only in the single cycle after the final write
    assign words_left_s = (word_idx_q != n_q);
    assign accept_s     = rx_valid && ((state_q == S_LEN) || ((state_q == S_DATA) && words_left_s));
    assign armed_s      = ((state_q == S_LEN) && (byte_cnt_q != 2'd0)) ||
                          ((state_q == S_DATA) && words_left_s);
    assign timeout_s    = TIMEOUT_EN && armed_s && !rx_valid && ((idle_q + 32'd1) == TIMEOUT_LIMIT);
    assign last_byte_s  = (byte_cnt_q == 2'd3);

    // Idle counter: clears on any byte, counts only while a frame is in progress
    always_comb begin
        idle_d = 32'd0;
        if (rx_valid || !armed_s) begin
            idle_d = 32'd0;
        end else begin
            idle_d = idle_q + 32'd1;
        end
    end

    // Next-state, byte assembly and ROM write generation
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        byte_cnt_d  = byte_cnt_q;
        n_d         = n_q;
        word_idx_d  = word_idx_q;
        rom_wren_d  = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_data_d  = rom_data_q;
        case (state_q)
            S_LEN: begin
                if (accept_s) begin
                    shift_d    = shift_next_s;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (!last_byte_s) begin
                        state_d = S_LEN;
                    end else if (shift_next_s == 32'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, shift_next_s} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d        = shift_next_s[IW-1:0];
                        word_idx_d = {IW{1'b0}};
                        state_d    = S_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_LEN;
                end
            end
            S_DATA: begin
                if (!words_left_s) begin
                    state_d = S_DONE;
                end else if (accept_s) begin
                    shift_d    = shift_next_s;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (last_byte_s) begin
                        rom_wren_d = 1'b1;
                        rom_addr_d = {word_idx_q[ROM_ADDRESS_BITWIDTH-3:0], 2'b00};
                        rom_data_d = shift_next_s;
                        word_idx_d = word_idx_q + {{(IW-1){1'b0}}, 1'b1};
                    end else begin
                        rom_wren_d = 1'b0;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE:  state_d = S_DONE;
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_ERROR;
        endcase
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERROR);
        cpu_rst_n_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_LEN;
            shift_q     <= 32'd0;
            byte_cnt_q  <= 2'd0;
            n_q         <= {IW{1'b0}};
            word_idx_q  <= {IW{1'b0}};
            idle_q      <= 32'd0;
            rom_wren_q  <= 1'b0;
            rom_addr_q  <= {ROM_ADDRESS_BITWIDTH{1'b0}};
            rom_data_q  <= 32'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            byte_cnt_q  <= byte_cnt_d;
            n_q         <= n_d;
            word_idx_q  <= word_idx_d;
            idle_q      <= idle_d;
            rom_wren_q  <= rom_wren_d;
            rom_addr_q  <= rom_addr_d;
            rom_data_q  <= rom_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    assign rom_wren       = rom_wren_q;
    assign rom_address    = rom_addr_q;
    assign rom_write_data = rom_data_q;
    assign done           = done_q;
    assign error          = error_q;
    assign cpu_reset_n    = cpu_rst_n_q;
endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader with a small ROM (4 words) and a 10-cycle
// timeout; random frames are checked against a byte-level frame-parsing model.
module tb_program_loader;
    localparam int AW   = 4;
    localparam int TO   = 10;
    localparam int MAXW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rom_wren;
    logic [AW-1:0] rom_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          done;
    logic          error;

    int vectors = 0;
    int miscompares = 0;

    logic [AW+31:0] got_q[$];
    logic [AW+31:0] exp_q[$];
    logic [7:0]     tx_q[$];
    logic           exp_done;
    logic           exp_error;

    program_loader #(.ROM_ADDRESS_BITWIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rom_wren(rom_wren), .rom_address(rom_address), .rom_write_data(rom_write_data),
        .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && rom_wren) got_q.push_back({rom_address, rom_write_data});
    end

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        got_q.delete();
    endtask

    // Reference: parse the byte list as a frame, assuming no inter-byte timeout.
    function automatic void model();
        int unsigned n;
        logic [31:0] w;
        logic [AW-1:0] a;
        exp_q.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        if (tx_q.size() < 4) return;
        n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
        if (n == 0) exp_done = 1'b1;
        else if (n > MAXW) exp_error = 1'b1;
        else begin
            for (int k = 0; k < int'(n); k++) begin
                if (4 * k + 7 < tx_q.size()) begin
                    w = {tx_q[4*k+7], tx_q[4*k+6], tx_q[4*k+5], tx_q[4*k+4]};
                    a = AW'(k * 4);
                    exp_q.push_back({a, w});
                end
            end
            exp_done = (exp_q.size() == int'(n));
        end
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if ({rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got wren=%b addr=%h data=%h cpu=%b done=%b err=%b, want all 0",
                     rom_wren, rom_address, rom_write_data, cpu_reset_n, done, error);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_two_words();
        logic [7:0] b[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00};
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b1, b[i]);
        vectors++;
        if ({rom_wren, rom_address, rom_write_data} !== {1'b1, 4'h0, 32'h00000013}) begin
            miscompares++;
            $display("FAIL two_first_write: got %b %h %h want 1 0 00000013", rom_wren, rom_address, rom_write_data);
        end
        for (int i = 8; i < 12; i++) step(1'b1, b[i]);
        vectors++;
        if ({rom_wren, rom_address, rom_write_data, done, cpu_reset_n} !== {1'b1, 4'h4, 32'h00100093, 2'b00}) begin
            miscompares++;
            $display("FAIL two_last_write: got %b %h %h done=%b cpu=%b want 1 4 00100093 0 0",
                     rom_wren, rom_address, rom_write_data, done, cpu_reset_n);
        end
        step(1'b0, 8'h00);
        vectors++;
        if ({rom_wren, rom_address, done, cpu_reset_n, error} !== {1'b0, 4'h4, 3'b110}) begin
            miscompares++;
            $display("FAIL two_done: got wren=%b addr=%h done=%b cpu=%b err=%b want 0 4 1 1 0",
                     rom_wren, rom_address, done, cpu_reset_n, error);
        end
        idle(3);
        vectors++;
        if (got_q.size() != 2) begin
            miscompares++;
            $display("FAIL two_count: got %0d writes want 2", got_q.size());
        end
    endtask

    task automatic test_zero_len();
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00);
        vectors++;
        if ({done, cpu_reset_n, error, rom_wren} !== 4'b1100) begin
            miscompares++;
            $display("FAIL zero_done: got done=%b cpu=%b err=%b wren=%b want 1 1 0 0", done, cpu_reset_n, error, rom_wren);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 8'h5A);
        vectors++;
        if (got_q.size() != 0 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_ignore: got %0d writes done=%b want 0 writes done=1", got_q.size(), done);
        end
    endtask

    task automatic test_too_long();
        logic [7:0] b[4] = '{8'h05, 8'h00, 8'h00, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, b[i]);
        vectors++;
        if ({error, cpu_reset_n, done, rom_wren} !== 4'b1000) begin
            miscompares++;
            $display("FAIL toolong_error: got err=%b cpu=%b done=%b wren=%b want 1 0 0 0", error, cpu_reset_n, done, rom_wren);
        end
        for (int i = 0; i < 8; i++) step(1'b1, 8'($urandom));
        idle(2);
        vectors++;
        if (got_q.size() != 0 || error !== 1'b1 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL toolong_ignore: got %0d writes err=%b done=%b want 0 1 0", got_q.size(), error, done);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b[6] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB};
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, b[i]);
        idle(TO - 1);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: got err=%b after %0d idle want 0", error, TO - 1);
        end
        idle(1);
        vectors++;
        if ({error, cpu_reset_n, done} !== 3'b100) begin
            miscompares++;
            $display("FAIL timeout_expire: got err=%b cpu=%b done=%b want 1 0 0", error, cpu_reset_n, done);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 8'hCC);
        idle(2);
        vectors++;
        if (got_q.size() != 0 || error !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_ignore: got %0d writes err=%b want 0 1", got_q.size(), error);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] b[8] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, b[i]);
            if (i != 7) idle(3);
        end
        idle(3);
        vectors++;
        if (got_q.size() != 1 || got_q[0] !== {4'h0, 32'hDEADBEEF} || done !== 1'b1) begin
            miscompares++;
            $display("FAIL gaps_write: got %0d writes first=%h done=%b want 1 0deadbeef 1",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 36'h0, done);
        end
    endtask

    task automatic test_reset_midload();
        logic [7:0] b[12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00};
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h00);
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({done, cpu_reset_n} !== 2'b00) begin
            miscompares++;
            $display("FAIL async_clear: got done=%b cpu=%b want 0 0 before any clock edge", done, cpu_reset_n);
        end
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, b[i]);
        #2;
        reset_n = 1'b0;
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, b[i]);
        idle(3);
        vectors++;
        if (got_q.size() != 2 || got_q[0] !== {4'h0, 32'h00000013} || got_q[1] !== {4'h4, 32'h00100093}
            || done !== 1'b1) begin
            miscompares++;
            $display("FAIL reload: got %0d writes done=%b want 2 writes (0:00000013, 4:00100093) done=1",
                     got_q.size(), done);
        end
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 12; it++) begin
            do_reset();
            tx_q.delete();
            n = (it == 0) ? MAXW : int'($urandom_range(0, MAXW + 1));
            for (int k = 0; k < 4; k++) tx_q.push_back(8'((n >> (8 * k)) & 255));
            if (n > MAXW) begin
                for (int k = 0; k < 4; k++) tx_q.push_back(8'($urandom));
            end else begin
                for (int k = 0; k < 4 * n; k++) tx_q.push_back(8'($urandom));
            end
            model();
            for (int k = 0; k < tx_q.size(); k++) begin
                step(1'b1, tx_q[k]);
                if (k != tx_q.size() - 1) idle(int'($urandom_range(0, TO - 1)));
            end
            idle(3);
            vectors++;
            if ({done, error, cpu_reset_n} !== {exp_done, exp_error, exp_done}) begin
                miscompares++;
                $display("FAIL rand_status[%0d]: got done=%b err=%b cpu=%b want %b %b %b",
                         it, done, error, cpu_reset_n, exp_done, exp_error, exp_done);
            end
            vectors++;
            if (got_q.size() != exp_q.size()) begin
                miscompares++;
                $display("FAIL rand_count[%0d]: got %0d writes want %0d", it, got_q.size(), exp_q.size());
            end else begin
                for (int k = 0; k < exp_q.size(); k++) begin
                    vectors++;
                    if (got_q[k] !== exp_q[k]) begin
                        miscompares++;
                        $display("FAIL rand_write[%0d.%0d]: got %h want %h", it, k, got_q[k], exp_q[k]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_gaps();
        test_reset_midload();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
